// File: rtl/core_pkg.sv
// Core-wide shared types and constants.
package core_pkg;

  // Data/address width of the core.
  localparam int unsigned Xlen = 32;

  // Identifies which requester issued a memory transaction.
  typedef enum logic {
    ReqFetch = 1'b0,
    ReqData  = 1'b1
  } mem_req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the data memory port.
interface mem_arbiter_if;
  import core_pkg::*;

  // Requester 0: instruction fetch
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [Xlen-1:0]   req0_addr_i;
  logic [Xlen-1:0]   req0_wdata_i;
  logic [Xlen/8-1:0] req0_wmask_i;
  logic [Xlen-1:0]   req0_rdata_o;
  logic              req0_rvalid_o;

  // Requester 1: load/store unit
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [Xlen-1:0]   req1_addr_i;
  logic [Xlen-1:0]   req1_wdata_i;
  logic [Xlen/8-1:0] req1_wmask_i;
  logic [Xlen-1:0]   req1_rdata_o;
  logic              req1_rvalid_o;

  // Shared memory port
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [Xlen-1:0]   mem_addr_o;
  logic [Xlen-1:0]   mem_wdata_o;
  logic [Xlen/8-1:0] mem_wmask_o;
  logic [Xlen-1:0]   mem_rdata_i;
  logic              mem_rvalid_i;

  logic              err_o;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_addr_i, req0_wdata_i, req0_wmask_i,
    output req0_ready_o, req0_rdata_o, req0_rvalid_o,
    input  req1_valid_i, req1_addr_i, req1_wdata_i, req1_wmask_i,
    output req1_ready_o, req1_rdata_o, req1_rvalid_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ready_i, mem_rdata_i, mem_rvalid_i,
    output err_o
  );

  // Environment side (requesters and memory)
  modport master (
    output req0_valid_i, req0_addr_i, req0_wdata_i, req0_wmask_i,
    input  req0_ready_o, req0_rdata_o, req0_rvalid_o,
    output req1_valid_i, req1_addr_i, req1_wdata_i, req1_wmask_i,
    input  req1_ready_o, req1_rdata_o, req1_rvalid_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ready_i, mem_rdata_i, mem_rvalid_i,
    input  err_o
  );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted memory requests; the head names
// the owner of the next response. Head is read combinationally so responses
// can be steered in the same cycle they arrive.
module mem_arb_id_fifo
  import core_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  mem_req_id_e data_i,
  input  logic        pop_i,
  output mem_req_id_e head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  mem_req_id_e     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage write; contents need no reset since count_q guards every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap modulo Depth; simultaneous push and pop leave count_q unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the data-memory port between fetch (requester 0) and load/store
// (requester 1). Round-robin grant, lock held across a memory stall, and an
// ID FIFO steering in-order responses back. Zero added latency both ways.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  bus
);

  logic        lock_q, lock_d;
  mem_req_id_e owner_q, owner_d;
  mem_req_id_e last_q, last_d;
  logic        err_q, err_d;

  mem_req_id_e gnt;
  logic        gnt_valid;
  logic        mem_valid;
  logic        accept;
  logic        stall;
  logic        rsp_pop;
  logic        fifo_full;
  logic        fifo_empty;
  mem_req_id_e fifo_head;

  // Grant selection: a locked owner keeps the port; otherwise round-robin on ties.
  always_comb begin
    gnt       = ReqFetch;
    gnt_valid = 1'b0;
    if (lock_q) begin
      gnt       = owner_q;
      gnt_valid = (owner_q == ReqData) ? bus.req1_valid_i : bus.req0_valid_i;
    end else begin
      case ({bus.req1_valid_i, bus.req0_valid_i})
        2'b01: begin
          gnt       = ReqFetch;
          gnt_valid = 1'b1;
        end
        2'b10: begin
          gnt       = ReqData;
          gnt_valid = 1'b1;
        end
        2'b11: begin
          gnt       = (last_q == ReqFetch) ? ReqData : ReqFetch;
          gnt_valid = 1'b1;
        end
        default: begin
          gnt       = ReqFetch;
          gnt_valid = 1'b0;
        end
      endcase
    end
  end

  // A full ID FIFO blocks the request path for the whole cycle (no bypass).
  assign mem_valid = gnt_valid && !fifo_full;
  assign accept    = mem_valid && bus.mem_ready_i;
  assign stall     = mem_valid && !bus.mem_ready_i;
  assign rsp_pop   = bus.mem_rvalid_i && !fifo_empty;

  assign bus.mem_valid_o  = mem_valid;
  assign bus.mem_addr_o   = (gnt == ReqData) ? bus.req1_addr_i  : bus.req0_addr_i;
  assign bus.mem_wdata_o  = (gnt == ReqData) ? bus.req1_wdata_i : bus.req0_wdata_i;
  assign bus.mem_wmask_o  = (gnt == ReqData) ? bus.req1_wmask_i : bus.req0_wmask_i;
  assign bus.req0_ready_o = accept && (gnt == ReqFetch);
  assign bus.req1_ready_o = accept && (gnt == ReqData);

  // Response data is broadcast; only rvalid is steered by the FIFO head.
  assign bus.req0_rdata_o  = bus.mem_rdata_i;
  assign bus.req1_rdata_o  = bus.mem_rdata_i;
  assign bus.req0_rvalid_o = rsp_pop && (fifo_head == ReqFetch);
  assign bus.req1_rvalid_o = rsp_pop && (fifo_head == ReqData);
  assign bus.err_o         = err_q;

  mem_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (gnt),
    .pop_i   (rsp_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state for lock, round-robin pointer and sticky error; a blocked (full) cycle changes nothing.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    if (accept) begin
      lock_d = 1'b0;
      last_d = gnt;
    end else if (stall) begin
      lock_d  = 1'b1;
      owner_d = gnt;
    end
    if (bus.mem_rvalid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // State registers; last_q resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= ReqFetch;
      last_q  <= ReqData;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants checked per cycle, accepted IDs pushed
// to a scoreboard queue and popped when the memory response is driven.
module tb_mem_arbiter;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MaxOutstanding (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int          n_err    = 0;
  int          n_checks = 0;
  int          sb[$];
  logic [31:0] addr0    = 32'h0000_1000;
  logic [31:0] addr1    = 32'h0000_2000;
  logic [31:0] rdata_v  = 32'hD000_0001;
  logic        exp_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req0_valid_i = 1'b0; bus.req0_addr_i = '0; bus.req0_wdata_i = '0; bus.req0_wmask_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_addr_i = '0; bus.req1_wdata_i = '0; bus.req1_wmask_i = '0;
    bus.mem_ready_i  = 1'b0; bus.mem_rdata_i = '0; bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ":mem_valid"}, bus.mem_valid_o, 0);
    chk({tag, ":mem_addr"},  bus.mem_addr_o, 0);
    chk({tag, ":mem_wdata"}, bus.mem_wdata_o, 0);
    chk({tag, ":mem_wmask"}, bus.mem_wmask_o, 0);
    chk({tag, ":ready0"},    bus.req0_ready_o, 0);
    chk({tag, ":ready1"},    bus.req1_ready_o, 0);
    chk({tag, ":rvalid0"},   bus.req0_rvalid_o, 0);
    chk({tag, ":rvalid1"},   bus.req1_rvalid_o, 0);
    chk({tag, ":rdata0"},    bus.req0_rdata_o, 0);
    chk({tag, ":rdata1"},    bus.req1_rdata_o, 0);
    chk({tag, ":err"},       bus.err_o, 0);
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+4, advance to next posedge+1.
  // egv/eid: whether a memory request is expected and which requester's fields it carries.
  task automatic step(input logic v0, input logic v1, input logic rdy, input logic rv,
                      input logic egv, input int eid, input string tag);
    int e;
    bus.req0_valid_i = v0; bus.req0_addr_i = addr0; bus.req0_wdata_i = '0; bus.req0_wmask_i = '0;
    bus.req1_valid_i = v1; bus.req1_addr_i = addr1;
    bus.req1_wdata_i = addr1 ^ 32'h5555_0000; bus.req1_wmask_i = 4'hF;
    bus.mem_ready_i  = rdy;
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = rv ? rdata_v : 32'h0;
    #3;
    chk({tag, ":err"},       bus.err_o, exp_err);
    chk({tag, ":mem_valid"}, bus.mem_valid_o, egv);
    chk({tag, ":mem_addr"},  bus.mem_addr_o, (eid == 1) ? addr1 : addr0);
    chk({tag, ":mem_wdata"}, bus.mem_wdata_o, (eid == 1) ? (addr1 ^ 32'h5555_0000) : 32'h0);
    chk({tag, ":mem_wmask"}, bus.mem_wmask_o, (eid == 1) ? 32'hF : 32'h0);
    chk({tag, ":ready0"},    bus.req0_ready_o, egv && rdy && (eid == 0));
    chk({tag, ":ready1"},    bus.req1_ready_o, egv && rdy && (eid == 1));
    if (rv) begin
      chk({tag, ":rdata0"}, bus.req0_rdata_o, rdata_v);
      chk({tag, ":rdata1"}, bus.req1_rdata_o, rdata_v);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, ":rvalid0"}, bus.req0_rvalid_o, e == 0);
        chk({tag, ":rvalid1"}, bus.req1_rvalid_o, e == 1);
        $display("[%0t] %s response data=%h -> req%0d", $time, tag, rdata_v, e);
      end else begin
        chk({tag, ":rvalid0"}, bus.req0_rvalid_o, 0);
        chk({tag, ":rvalid1"}, bus.req1_rvalid_o, 0);
        exp_err = 1'b1;
        $display("[%0t] %s response data=%h dropped (nothing outstanding)", $time, tag, rdata_v);
      end
      rdata_v = rdata_v + 32'h11;
    end else begin
      chk({tag, ":rvalid0"}, bus.req0_rvalid_o, 0);
      chk({tag, ":rvalid1"}, bus.req1_rvalid_o, 0);
    end
    if (egv && rdy) begin
      sb.push_back(eid);
      $display("[%0t] %s accept req%0d addr=%h", $time, tag, eid, (eid == 1) ? addr1 : addr0);
      if (eid == 0) addr0 = addr0 + 32'h4;
      else          addr1 = addr1 + 32'h4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all inputs low: every output is 0.
    rst_n = 1'b0;
    drive_idle();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both valid, memory always ready: 0,1,0,1; responses one cycle later.
    step(1, 1, 1, 0, 1, 0, "rr0");
    step(1, 1, 1, 1, 1, 1, "rr1");
    step(1, 1, 1, 1, 1, 0, "rr2");
    step(1, 1, 1, 1, 1, 1, "rr3");
    step(1, 0, 1, 1, 1, 0, "rr4");
    step(0, 0, 1, 1, 0, 0, "rr5");

    // last_q is now requester 0, so an unlocked tie would pick 1; the lock keeps req0.
    step(1, 0, 0, 0, 1, 0, "stall0");
    step(1, 1, 0, 0, 1, 0, "stall1");
    step(1, 1, 0, 0, 1, 0, "stall2");
    step(1, 1, 1, 0, 1, 0, "stall3");
    step(0, 1, 1, 1, 1, 1, "stall4");
    step(0, 0, 1, 1, 0, 0, "stall5");

    // Two outstanding fills the FIFO; a response does not unblock the same cycle.
    step(1, 0, 1, 0, 1, 0, "full0");
    step(1, 0, 1, 0, 1, 0, "full1");
    step(1, 0, 1, 0, 0, 0, "full2");
    step(1, 0, 1, 1, 0, 0, "full3");
    step(1, 0, 1, 0, 1, 0, "full4");
    step(0, 0, 1, 1, 0, 0, "full5");
    step(0, 0, 1, 1, 0, 0, "full6");

    // Accept and response together at count 1: response goes to older ID, count stays 1.
    step(0, 1, 1, 0, 1, 1, "pp0");
    step(1, 0, 1, 1, 1, 0, "pp1");
    step(0, 1, 1, 0, 1, 1, "pp2");
    step(1, 0, 1, 0, 0, 0, "pp3");
    step(1, 0, 1, 1, 0, 0, "pp4");
    step(1, 0, 1, 1, 1, 0, "pp5");
    step(0, 0, 1, 1, 0, 0, "pp6");

    // Response with nothing outstanding: dropped, err_o sticks.
    step(0, 0, 1, 1, 0, 0, "err0");
    step(0, 0, 1, 0, 0, 0, "err1");
    step(0, 0, 0, 0, 0, 0, "err2");

    // Reset mid-stall with one outstanding: asynchronous clear of all state.
    step(0, 1, 1, 0, 1, 1, "rst0");
    step(1, 0, 0, 0, 1, 0, "rst1");
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    sb.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Late response for a pre-reset request flags err; first tie goes to requester 0.
    step(0, 0, 1, 1, 0, 0, "post0");
    step(1, 1, 1, 0, 1, 0, "post1");
    step(1, 1, 1, 1, 1, 1, "post2");
    step(0, 0, 1, 1, 0, 0, "post3");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
